lsq_arbiter: RTL

Round-robin arbiter that shares the single request/response port of the load-store queue among NREQ requesters, such as the fetch unit and the load/store unit. It assigns each issued request a 3-bit LSQ id from a wrapping counter and records its owner in an 8-entry table. In-order LSQ responses are then routed back to the owning requester. It sits between the core's memory clients and the LSQ and is the only block driving the LSQ request port.

---
 rtl/lsq_arb_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/lsq_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/lsq_arb_pkg.sv
// lsq_arb_pkg: shared widths and encodings for the LSQ request arbiter
package lsq_arb_pkg;
    localparam int LSQ_ID_W = 3;
    localparam int MAX_OUT = 8;
    localparam int OWN_W = 2;
    localparam logic REQ_LOAD = 1'b0;
    localparam logic REQ_STORE = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module rr_arbiter
    import lsq_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [OWN_W-1:0] winner
);
    // Scan offsets from farthest to nearest so the nearest requester overwrites last
    always_comb begin
        winner = '0;
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            for (int i = 0; i < NREQ; i++)
                if (req[i] && i == (int'(ptr) + k) % NREQ) begin
                    winner = OWN_W'(i);
                    grant = '0;
                    grant[i] = 1'b1;
                end
    end
endmodule

// File: rtl/lsq_arbiter.sv
// lsq_arbiter: round-robin sharing of the LSQ request port with in-order response routing
module lsq_arbiter
    import lsq_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int MAX_OUT = lsq_arb_pkg::MAX_OUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     m_req_sig,
    input  logic [NREQ-1:0]     m_req_type,
    input  logic [32*NREQ-1:0]  m_req_addr,
    input  logic [32*NREQ-1:0]  m_req_data,
    output logic [NREQ-1:0]     m_ready,
    output logic [NREQ-1:0]     m_resp,
    input  logic [NREQ-1:0]     m_resp_ack,
    output logic                m_resp_type,
    output logic [31:0]         m_resp_data,
    output logic                lsq_req_sig,
    output logic                lsq_req_type,
    output logic [LSQ_ID_W-1:0] lsq_req_id,
    output logic [31:0]         lsq_req_addr,
    output logic [31:0]         lsq_req_data,
    input  logic                lsq_ready,
    input  logic                lsq_resp,
    output logic                lsq_resp_ack,
    input  logic                lsq_resp_type,
    input  logic [LSQ_ID_W-1:0] lsq_resp_id,
    input  logic [31:0]         lsq_resp_data,
    output logic                id_err
);
    logic [LSQ_ID_W-1:0] wr_id, rd_id;
    logic [3:0] count;
    logic [OWN_W-1:0] rr_ptr, winner, cur_owner;
    logic [OWN_W-1:0] owner [MAX_OUT];
    logic [NREQ-1:0] grant, owner_oh;
    logic grant_ok, resp_ok, win_type;
    logic [31:0] win_addr, win_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req(m_req_sig),
        .ptr(rr_ptr),
        .grant(grant),
        .winner(winner)
    );

    // The !lsq_req_sig term spaces pushes two cycles apart so lsq_ready reflects the last one
    assign grant_ok = rst && lsq_ready && !lsq_req_sig && count < 4'(MAX_OUT) && |m_req_sig;
    assign cur_owner = owner[rd_id];
    assign resp_ok = rst && lsq_resp && count != 4'd0;
    assign m_ready = grant_ok ? grant : '0;
    assign m_resp = resp_ok ? owner_oh : '0;
    assign lsq_resp_ack = |(m_resp & m_resp_ack);
    assign m_resp_type = lsq_resp_type;
    assign m_resp_data = lsq_resp_data;

    always_comb begin
        win_type = 1'b0;
        win_addr = '0;
        win_data = '0;
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_oh[i] = cur_owner == OWN_W'(i);
            if (grant[i]) begin
                win_type = m_req_type[i];
                win_addr = m_req_addr[32*i +: 32];
                win_data = m_req_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsq_req_sig <= 1'b0;
            lsq_req_type <= 1'b0;
            lsq_req_id <= '0;
            lsq_req_addr <= '0;
            lsq_req_data <= '0;
            id_err <= 1'b0;
            wr_id <= '0;
            rd_id <= '0;
            count <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < MAX_OUT; i++) owner[i] <= '0;
        end else begin
            lsq_req_sig <= grant_ok;
            if (grant_ok) begin
                lsq_req_type <= win_type;
                lsq_req_id <= wr_id;
                lsq_req_addr <= win_addr;
                lsq_req_data <= win_data;
                owner[wr_id] <= winner;
                wr_id <= wr_id + 1'b1;
                rr_ptr <= (winner == OWN_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
            if (lsq_resp_ack) rd_id <= rd_id + 1'b1;
            count <= count + 4'(grant_ok) - 4'(lsq_resp_ack);
            if (lsq_resp && (count == 4'd0 || lsq_resp_id != rd_id)) id_err <= 1'b1;
        end
    end
endmodule
